// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and receiver state encoding.
// Used by both the receiver and the transmitter so the frame format lives in one place.
package uart_pkg;

   localparam int   DATA_BITS   = 8;
   localparam int   STOP_BITS   = 2;
   localparam bit   PARITY_EVEN = 1'b1;
   localparam logic IDLE_LEVEL  = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2,
      S_WAIT_HIGH
   } rx_state_e;

endpackage

// File: rtl/uart_rx_parity.sv
// Running XOR of received data bits; clear wins over enable.
module uart_rx_parity (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   input  logic bit_i,
   output logic par_o
);

   logic acc_q, acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clr_i)
         acc_d = 1'b0;
      else if (en_i)
         acc_d = acc_q ^ bit_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc_q <= 1'b0;
      else
         acc_q <= acc_d;
   end

   assign par_o = acc_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start, 8 data LSB first, even parity, 2 stop bits.
// Define UART_RX_SYNC_EN to put a 2-flop synchronizer on bitReceived.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bitReceived,
   output logic [7:0] dataOut,
   output logic       isValid,
   output logic       parityError,
   output logic       frameError,
   output logic       busy
);

   localparam int              HALF      = (CLKS_PER_BIT - 1) / 2;
   localparam int              BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0]   BAUD_HALF = BW'(HALF);
   localparam logic [2:0]      LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic            PAR_SENSE = PARITY_EVEN ? 1'b0 : 1'b1;

   logic rx_s;

`ifdef UART_RX_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sync_q <= {2{IDLE_LEVEL}};
      else
         sync_q <= {sync_q[0], bitReceived};
   end

   assign rx_s = sync_q[1];
`else
   assign rx_s = bitReceived;
`endif

   rx_state_e     state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shadow_q, shadow_d;
   logic [7:0]    data_q, data_d;
   logic          stop1_q, stop1_d;
   logic          perr_pend_q, perr_pend_d;
   logic          perr_q, perr_d;
   logic          ferr_q, ferr_d;
   logic          valid_q, valid_d;
   logic          tick;
   logic          par_clr, par_en, par_acc;

   uart_rx_parity u_par (
      .clk   (clk),
      .rst   (rst),
      .clr_i (par_clr),
      .en_i  (par_en),
      .bit_i (rx_s),
      .par_o (par_acc)
   );

   // START samples at mid-bit, so the later bit states land mid-bit as well.
   always_comb begin
      tick = (state_q == S_START) ? (baud_q == BAUD_HALF) : (baud_q == BAUD_LAST);
   end

   always_comb begin
      baud_d = baud_q + BW'(1);
      if (state_q == S_IDLE || state_q == S_WAIT_HIGH || tick)
         baud_d = '0;
   end

   always_comb begin
      state_d     = state_q;
      bitcnt_d    = bitcnt_q;
      shadow_d    = shadow_q;
      data_d      = data_q;
      stop1_d     = stop1_q;
      perr_pend_d = perr_pend_q;
      perr_d      = perr_q;
      ferr_d      = ferr_q;
      valid_d     = 1'b0;
      par_clr     = 1'b0;
      par_en      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (rx_s != IDLE_LEVEL) begin
               // At one clock per bit the detecting edge already is the start sample.
               if (CLKS_PER_BIT == 1) begin
                  state_d  = S_DATA;
                  bitcnt_d = '0;
                  par_clr  = 1'b1;
               end else begin
                  state_d = S_START;
               end
            end
         end
         S_START: begin
            if (tick) begin
               if (rx_s != IDLE_LEVEL) begin
                  state_d  = S_DATA;
                  bitcnt_d = '0;
                  par_clr  = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               shadow_d[bitcnt_q] = rx_s;
               par_en             = 1'b1;
               bitcnt_d           = bitcnt_q + 3'd1;
               if (bitcnt_q == LAST_BIT)
                  state_d = S_PARITY;
            end
         end
         S_PARITY: begin
            if (tick) begin
               perr_pend_d = par_acc ^ rx_s ^ PAR_SENSE;
               state_d     = S_STOP1;
            end
         end
         S_STOP1: begin
            if (tick) begin
               stop1_d = rx_s;
               state_d = S_STOP2;
            end
         end
         S_STOP2: begin
            if (tick) begin
               data_d  = shadow_q;
               perr_d  = perr_pend_q;
               ferr_d  = !(stop1_q && rx_s);
               valid_d = 1'b1;
               state_d = (rx_s == IDLE_LEVEL) ? S_IDLE : S_WAIT_HIGH;
            end
         end
         S_WAIT_HIGH: begin
            // A held-low break must not look like a string of start bits.
            if (rx_s == IDLE_LEVEL)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         baud_q      <= '0;
         bitcnt_q    <= '0;
         shadow_q    <= '0;
         data_q      <= '0;
         stop1_q     <= 1'b0;
         perr_pend_q <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bitcnt_q    <= bitcnt_d;
         shadow_q    <= shadow_d;
         data_q      <= data_d;
         stop1_q     <= stop1_d;
         perr_pend_q <= perr_pend_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
         valid_q     <= valid_d;
      end
   end

   assign dataOut     = data_q;
   assign isValid     = valid_q;
   assign parityError = perr_q;
   assign frameError  = ferr_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: one instance at 1 clk/bit, one at 4 clk/bit.
module tb_uart_receiver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       line1 = 1'b1;
   logic       line4 = 1'b1;
   logic [7:0] data1, data4;
   logic       vld1, vld4, perr1, perr4, ferr1, ferr4, busy1, busy4;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      int         c;
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } pulse_t;

   pulse_t q1[$];
   pulse_t q4[$];

   typedef struct {
      logic [7:0] d;
      logic       flip_par;
      logic       s1;
      logic       s2;
      logic       exp_pe;
      logic       exp_fe;
   } vec_t;

   uart_receiver #(.CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .rst(rst), .bitReceived(line1), .dataOut(data1), .isValid(vld1),
      .parityError(perr1), .frameError(ferr1), .busy(busy1)
   );

   uart_receiver #(.CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .rst(rst), .bitReceived(line4), .dataOut(data4), .isValid(vld4),
      .parityError(perr4), .frameError(ferr4), .busy(busy4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (vld1) q1.push_back('{cyc, data1, perr1, ferr1});
      if (vld4) q4.push_back('{cyc, data4, perr4, ferr4});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // bit 0 = start, 1..8 = data LSB first, 9 = parity, 10/11 = stops
   function automatic logic [11:0] frame(input logic [7:0] d, input logic flip, input logic s1,
                                         input logic s2);
      logic [11:0] f;
      f[0]   = 1'b0;
      f[8:1] = d;
      f[9]   = (^d) ^ flip;
      f[10]  = s1;
      f[11]  = s2;
      return f;
   endfunction

   // Returns the cycle number of the edge that samples the start bit.
   task automatic send1(input logic [11:0] f, output int k);
      k = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         line1 = f[i];
         if (i == 0) k = cyc + 1;
      end
   endtask

   task automatic send4(input logic [11:0] f, output int k);
      k = 0;
      for (int i = 0; i < 12; i++) begin
         for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            line4 = f[i];
            if (i == 0 && j == 0) k = cyc + 1;
         end
      end
   endtask

   task automatic idle1(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         line1 = 1'b1;
      end
   endtask

   vec_t vecs[5];

   initial begin
      int k, k2;

      vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      #12;
      chk("rst dataOut", 32'(data1), 32'h00);
      chk("rst isValid", 32'(vld1), 32'h0);
      chk("rst flags", 32'({perr1, ferr1}), 32'h0);
      chk("rst busy", 32'({busy1, busy4}), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      idle1(3);

      // 0xA5 on the wire: start then 1,0,1,0,0,1,0,1, parity 0, stops 1,1
      chk("A5 frame bits", 32'(frame(8'hA5, 1'b0, 1'b1, 1'b1)), 32'hD4A);

      foreach (vecs[v]) begin
         q1.delete();
         send1(frame(vecs[v].d, vecs[v].flip_par, vecs[v].s1, vecs[v].s2), k);
         idle1(3);
         chk($sformatf("vec%0d pulses", v), 32'(q1.size()), 32'd1);
         if (q1.size() > 0) begin
            chk($sformatf("vec%0d latency", v), 32'(q1[0].c - k), 32'd11);
            chk($sformatf("vec%0d data", v), 32'(q1[0].d), 32'(vecs[v].d));
            chk($sformatf("vec%0d parityError", v), 32'(q1[0].pe), 32'(vecs[v].exp_pe));
            chk($sformatf("vec%0d frameError", v), 32'(q1[0].fe), 32'(vecs[v].exp_fe));
         end
         chk($sformatf("vec%0d held data", v), 32'(data1), 32'(vecs[v].d));
         chk($sformatf("vec%0d held flags", v), 32'({perr1, ferr1}),
             32'({vecs[v].exp_pe, vecs[v].exp_fe}));
      end

      // Break: stop2 low and the line kept low for 5 more cycles.
      q1.delete();
      send1(frame(8'h3C, 1'b0, 1'b1, 1'b0), k);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("break busy %0d", i), 32'(busy1), 32'h1);
         line1 = 1'b0;
      end
      @(negedge clk);
      line1 = 1'b1;
      @(negedge clk);
      chk("break busy after high", 32'(busy1), 32'h0);
      chk("break pulses", 32'(q1.size()), 32'd1);
      if (q1.size() > 0) begin
         chk("break data", 32'(q1[0].d), 32'h3C);
         chk("break flags", 32'({q1[0].pe, q1[0].fe}), 32'b01);
      end
      idle1(2);
      q1.delete();
      send1(frame(8'hFF, 1'b0, 1'b1, 1'b1), k);
      idle1(3);
      chk("post-break pulses", 32'(q1.size()), 32'd1);
      if (q1.size() > 0) begin
         chk("post-break data", 32'(q1[0].d), 32'hFF);
         chk("post-break flags", 32'({q1[0].pe, q1[0].fe}), 32'b00);
      end

      // Back-to-back 0x00 then 0xFF, no idle gap.
      q1.delete();
      send1(frame(8'h00, 1'b0, 1'b1, 1'b1), k);
      send1(frame(8'hFF, 1'b0, 1'b1, 1'b1), k2);
      idle1(3);
      chk("b2b pulses", 32'(q1.size()), 32'd2);
      if (q1.size() > 1) begin
         chk("b2b spacing", 32'(q1[1].c - q1[0].c), 32'd12);
         chk("b2b data0", 32'(q1[0].d), 32'h00);
         chk("b2b data1", 32'(q1[1].d), 32'hFF);
         chk("b2b latency", 32'(q1[1].c - k2), 32'd11);
      end

      // Reset during data bit 4 of 0x77.
      q1.delete();
      begin
         logic [11:0] f;
         f = frame(8'h77, 1'b0, 1'b1, 1'b1);
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            line1 = f[i];
         end
      end
      #2 rst = 1'b1;
      #1;
      chk("midrst outputs", 32'({data1, vld1, perr1, ferr1, busy1}), 32'h0);
      #1 rst = 1'b0;
      line1 = 1'b1;
      idle1(14);
      chk("midrst no pulse", 32'(q1.size()), 32'd0);
      send1(frame(8'h5A, 1'b0, 1'b1, 1'b1), k);
      idle1(3);
      chk("after rst pulses", 32'(q1.size()), 32'd1);
      if (q1.size() > 0) begin
         chk("after rst data", 32'(q1[0].d), 32'h5A);
         chk("after rst flags", 32'({q1[0].pe, q1[0].fe}), 32'b00);
      end

      // 4 clk/bit: single-cycle glitch must be rejected at the mid-bit resample.
      q4.delete();
      @(negedge clk);
      line4 = 1'b0;
      @(negedge clk);
      chk("glitch busy", 32'(busy4), 32'h1);
      line4 = 1'b1;
      for (int i = 0; i < 8; i++) @(negedge clk);
      chk("glitch idle", 32'(busy4), 32'h0);
      chk("glitch no pulse", 32'(q4.size()), 32'd0);

      // Start sampled at k+2; stop2 is bit 11, sampled mid-bit at k+44+2.
      send4(frame(8'hC3, 1'b0, 1'b1, 1'b1), k);
      for (int i = 0; i < 6; i++) @(negedge clk);
      chk("N4 pulses", 32'(q4.size()), 32'd1);
      if (q4.size() > 0) begin
         chk("N4 latency", 32'(q4[0].c - k), 32'd46);
         chk("N4 data", 32'(q4[0].d), 32'hC3);
         chk("N4 flags", 32'({q4[0].pe, q4[0].fe}), 32'b00);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
